// File: rtl/sw_input_port.sv
// sw_input_port: synchronises and debounces the board switches and presents
// the debounced state to the data-memory stage as two zero-extended 32-bit
// input-port words. It also provides a one-cycle change strobe and a sticky
// change flag that software polls and clears.
//
// Optional build macro: SW_INPUT_EDGE_COUNT_EN adds change_count[15:0]. This
// counter advances once per sw_stable update event and wraps at 16 bits.
//
// Strobe semantics: sw_changed acts as a valid pulse with no ready. It is
// high for exactly one cycle after each edge on which sw_stable took a new
// value. It is never held or back-pressured, and consecutive updates give
// consecutive high cycles.
module sw_input_port #(
  parameter int SW_WIDTH        = 8,
  // Flops per synchroniser chain; must be at least 2.
  parameter int SYNC_STAGES     = 2,
  // Consecutive disagreeing edges before a stable bit flips; must be >= 1.
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic [SW_WIDTH-1:0] sw,
  output logic [31:0]         in_port0,
  output logic [31:0]         in_port1,
  output logic [SW_WIDTH-1:0] sw_stable,
  output logic                sw_changed,
  output logic                change_pending,
  input  logic                change_clr
`ifdef SW_INPUT_EDGE_COUNT_EN
  ,
  output logic [15:0]         change_count
`endif
);

  localparam int LO_W  = SW_WIDTH / 2;
  localparam int HI_W  = SW_WIDTH - LO_W;
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  // Count value reached on the last disagreeing edge before the stable bit flips.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // Synchroniser chain, stage 0 samples the raw pins. The last stage is the
  // only value the debouncer ever looks at.
  logic [SW_WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [SW_WIDTH-1:0] s;

  // Per-bit debounce counters and their next values.
  logic [CNT_W-1:0]    cnt_q [SW_WIDTH];
  logic [CNT_W-1:0]    cnt_d [SW_WIDTH];
  logic [SW_WIDTH-1:0] stable_d;
  logic                update;

  assign s = sync_q[SYNC_STAGES-1];

  // Plain flop chain per bit: no logic between stages.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= '0;
      end
    end else begin
      sync_q[0] <= sw;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        sync_q[k] <= sync_q[k-1];
      end
    end
  end

  // Debounce decision per bit. Agreement clears the count. Disagreement
  // counts up, and on the DEBOUNCE_CYCLES-th consecutive disagreeing edge
  // the stable bit takes the synchronised value and the count restarts.
  // Because of this the counter can never pass CNT_LAST, so it never wraps.
  always_comb begin
    stable_d = sw_stable;
    for (int i = 0; i < SW_WIDTH; i++) begin
      cnt_d[i] = '0;
      if (s[i] != sw_stable[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          stable_d[i] = s[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_ONE;
        end
      end
    end
  end

  // One update event per edge, however many bits flip together on it.
  assign update = (stable_d != sw_stable);

  // Debounce state registers. Reset discards any partial counts.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      sw_stable <= '0;
      for (int i = 0; i < SW_WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sw_stable <= stable_d;
      for (int i = 0; i < SW_WIDTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // Change strobe and sticky flag. A set on the same edge as a clear
  // request wins, so software can never lose an update it has not yet seen.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      sw_changed     <= 1'b0;
      change_pending <= 1'b0;
    end else begin
      sw_changed <= update;
      if (update) begin
        change_pending <= 1'b1;
      end else if (change_clr) begin
        change_pending <= 1'b0;
      end
    end
  end

`ifdef SW_INPUT_EDGE_COUNT_EN
  // Update-event counter. It wraps naturally and ignores change_clr.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      change_count <= '0;
    end else if (update) begin
      change_count <= change_count + 16'd1;
    end
  end
`endif

  // The memory-mapped input words come straight from the debounced state.
  assign in_port0 = {{(32-LO_W){1'b0}}, sw_stable[LO_W-1:0]};
  assign in_port1 = {{(32-HI_W){1'b0}}, sw_stable[SW_WIDTH-1:LO_W]};

endmodule
